alu_seq: RTL and testbench

Sequential, parametrised accumulator ALU for the processor datapath, successor to the combinational ADD/SUB unit. It owns the accumulator register and executes eight operations on accumulator and operand: logic, shift, add/sub with status flags, and an optional multi-cycle shift-add multiply. Commands are accepted over a valid/ready handshake from the control unit. Each result is announced with a one-cycle `out_valid` pulse.

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential accumulator ALU: logic/shift/add/sub with status flags behind a valid/ready command port.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier; otherwise op 111 is a single-cycle no-op.
module alu_seq #(
  parameter int DATA_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [DATA_LENGTH-1:0] operand,
  output logic [DATA_LENGTH-1:0] acc_out,
  output logic                   out_valid,
  output logic                   zero,
  output logic                   neg,
  output logic                   carry,
  output logic                   ovf
);
  localparam int DL = DATA_LENGTH;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  logic [DL-1:0] acc_q;
  logic          zero_q, neg_q, carry_q, ovf_q, out_valid_q;

  logic [DL-1:0] res_d;
  logic          zero_d, neg_d, carry_d, ovf_d;
  logic [DL:0]   sum, diff;

  assign sum  = {1'b0, acc_q} + {1'b0, operand};
  assign diff = {1'b0, acc_q} - {1'b0, operand};

  // Single-cycle datapath; the top bit of diff is the unsigned borrow.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_d   = acc_q;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = sum[DL-1:0];
        carry_d = sum[DL];
        ovf_d   = (acc_q[DL-1] == operand[DL-1]) && (sum[DL-1] != acc_q[DL-1]);
      end
      OP_SUB: begin
        res_d   = diff[DL-1:0];
        carry_d = diff[DL];
        ovf_d   = (acc_q[DL-1] != operand[DL-1]) && (diff[DL-1] != acc_q[DL-1]);
      end
      OP_AND:  res_d = acc_q & operand;
      OP_OR:   res_d = acc_q | operand;
      OP_XOR:  res_d = acc_q ^ operand;
      OP_LOAD: res_d = operand;
      OP_SHL: begin
        res_d   = {acc_q[DL-2:0], 1'b0};
        carry_d = acc_q[DL-1];
      end
      default: res_d = acc_q;
    endcase
    zero_d = (res_d == '0);
    neg_d  = res_d[DL-1];
    // Op 111 on the single-cycle path is a no-op that preserves the previous flags.
    if (op == OP_MUL) begin
      zero_d  = zero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
    end
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(DL + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q;
  logic [2*DL-1:0] mcand_q, prod_q, prod_d;
  logic [DL-1:0]   mplier_q;
  logic [CW-1:0]   cnt_q;

  assign in_ready = (state_q == S_IDLE);
  // Multiplicand shifts left while multiplier shifts right: one partial product per step.
  assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign in_ready = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      if (state_q == S_MUL) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        prod_q   <= prod_d;
        cnt_q    <= cnt_q + CW'(1);
        if (cnt_q == CW'(DL - 1)) begin
          acc_q       <= prod_d[DL-1:0];
          zero_q      <= (prod_d[DL-1:0] == '0);
          neg_q       <= prod_d[DL-1];
          carry_q     <= |prod_d[2*DL-1:DL];
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      end else
`endif
      if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
        if (op == OP_MUL) begin
          mcand_q  <= {{DL{1'b0}}, acc_q};
          mplier_q <= operand;
          prod_q   <= '0;
          cnt_q    <= '0;
          state_q  <= S_MUL;
        end else
`endif
        begin
          acc_q       <= res_d;
          zero_q      <= zero_d;
          neg_q       <= neg_d;
          carry_q     <= carry_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign acc_out   = acc_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed commands push hand-computed results, a monitor pops on out_valid.
// Multiplier scenarios are included when ALU_MUL_EN is defined, the op-111 no-op scenario otherwise.
module tb_alu_seq;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] operand;
  logic [15:0] acc_out;
  logic        out_valid;
  logic        zero, neg, carry, ovf;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  // Expected response packed as {acc, zero, neg, carry, ovf}.
  logic [19:0] exp_q[$];
  logic [19:0] exp_r;

  alu_seq #(.DATA_LENGTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand  (operand),
    .acc_out  (acc_out),
    .out_valid(out_valid),
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] res(input logic [15:0] a, input logic z, input logic n,
                                      input logic c, input logic v);
    return {a, z, n, c, v};
  endfunction

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_r = exp_q.pop_front();
        check($sformatf("result%0d {acc,z,n,c,v}", pops), {12'd0, acc_out, zero, neg, carry, ovf},
              {12'd0, exp_r});
        pops++;
      end
    end
  end

  // Present a command until accepted; push its expected result on the accept edge.
  task automatic issue(input logic [2:0] o, input logic [15:0] d, input logic [19:0] exp, input bit push);
    int waited = 0;
    op       = o;
    operand  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) exp_q.push_back(exp);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"},       {16'd0, acc_out}, 32'd0);
    check({tag, "_flags"},     {28'd0, zero, neg, carry, ovf}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
  endtask

`ifdef ALU_MUL_EN
  int low_cycles;
`endif

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = 3'b000;
    operand  = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back adds from reset: one result per cycle.
    issue(OP_ADD, 16'h0001, res(16'h0001, 0, 0, 0, 0), 1);
    issue(OP_ADD, 16'h0001, res(16'h0002, 0, 0, 0, 0), 1);
    issue(OP_ADD, 16'h0001, res(16'h0003, 0, 0, 0, 0), 1);
    issue(OP_ADD, 16'h0001, res(16'h0004, 0, 0, 0, 0), 1);

    issue(OP_LOAD, 16'h8001, res(16'h8001, 0, 1, 0, 0), 1);
    issue(OP_SHL,  16'h0000, res(16'h0002, 0, 0, 1, 0), 1);

    issue(OP_LOAD, 16'h7FFF, res(16'h7FFF, 0, 0, 0, 0), 1);
    issue(OP_ADD,  16'h0001, res(16'h8000, 0, 1, 0, 1), 1);

    issue(OP_LOAD, 16'h0003, res(16'h0003, 0, 0, 0, 0), 1);
    issue(OP_SUB,  16'h0005, res(16'hFFFE, 0, 1, 1, 0), 1);
`ifndef ALU_MUL_EN
    // No-op keeps acc and the non-trivial flags left by the subtract.
    issue(OP_MUL,  16'h0007, res(16'hFFFE, 0, 1, 1, 0), 1);
`endif
    issue(OP_XOR,  16'hFFFE, res(16'h0000, 1, 0, 0, 0), 1);

    issue(OP_LOAD, 16'hF0F0, res(16'hF0F0, 0, 1, 0, 0), 1);
    issue(OP_AND,  16'h0FF0, res(16'h00F0, 0, 0, 0, 0), 1);
    issue(OP_OR,   16'h0F00, res(16'h0FF0, 0, 0, 0, 0), 1);

    issue(OP_LOAD, 16'hFFFF, res(16'hFFFF, 0, 1, 0, 0), 1);
    issue(OP_ADD,  16'h0001, res(16'h0000, 1, 0, 1, 0), 1);
    issue(OP_LOAD, 16'h8000, res(16'h8000, 0, 1, 0, 0), 1);
    issue(OP_SUB,  16'h0001, res(16'h7FFF, 0, 0, 0, 1), 1);

`ifdef ALU_MUL_EN
    issue(OP_LOAD, 16'h0012, res(16'h0012, 0, 0, 0, 0), 1);
    issue(OP_MUL,  16'h0034, res(16'h03A8, 0, 0, 0, 0), 1);
    low_cycles = 0;
    while (low_cycles < 100) begin
      @(negedge clk);
      if (in_ready) break;
      low_cycles++;
    end
    check("mul_in_ready_low_cycles", low_cycles, 32'd16);

    issue(OP_LOAD, 16'h0100, res(16'h0100, 0, 0, 0, 0), 1);
    issue(OP_MUL,  16'h0100, res(16'h0000, 1, 0, 1, 0), 1);
    issue(OP_ADD,  16'h0001, res(16'h0001, 0, 0, 0, 0), 1);

    // Abort a multiply with reset: no result may ever appear for it.
    issue(OP_LOAD, 16'h0005, res(16'h0005, 0, 0, 0, 0), 1);
    issue(OP_MUL,  16'h0007, res(16'h0023, 0, 0, 0, 0), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_mul_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_acc", {16'd0, acc_out}, 32'd0);
`else
    issue(OP_LOAD, 16'h0005, res(16'h0005, 0, 0, 0, 0), 1);
    issue(OP_MUL,  16'h0007, res(16'h0005, 0, 0, 0, 0), 1);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
